// File: rtl/wb_result_queue_pkg.sv
// ============================================================================
// Module : wb_result_queue_pkg
// Brief  : Shared backend writeback types and per-unit result-queue depths.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package wb_result_queue_pkg;

  typedef struct packed {
    logic        en;
    logic        we;
    logic [5:0]  robIdx;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [4:0]  exccode;
    logic        irq_enable;
  } WBData;

  // Result-queue depths for each slow unit sharing a writeback slot.
  localparam int c_DIV_WBQ_DEPTH   = 4;
  localparam int c_FDIV_WBQ_DEPTH  = 4;
  localparam int c_FMISC_WBQ_DEPTH = 2;

endpackage

`default_nettype wire

// File: rtl/wb_result_queue.sv
// ============================================================================
// Module : wb_result_queue
// Brief  : Circular buffer holding multi-cycle unit results until the shared
//          writeback port grants a slot. Rev 1.0
// ============================================================================
`default_nettype none

module wb_result_queue
  import wb_result_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  WBData                  in_data,
  output logic                   in_ready,
  output WBData                  out_data,
  input  logic                   out_grant,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count
);

  localparam int c_AW = $clog2(DEPTH);

  logic [c_AW:0] r_head;
  logic [c_AW:0] r_tail;
  WBData         r_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_empty  = (r_head == r_tail);
  assign w_full   = (r_head[c_AW-1:0] == r_tail[c_AW-1:0]) &&
                    (r_head[c_AW] != r_tail[c_AW]);
  assign count    = r_tail - r_head;
  // Depends only on pointer state, so no path from out_grant or in_data.
  assign in_ready = !w_full;
  assign w_push   = in_data.en && in_ready;
  assign w_pop    = !w_empty && out_grant;

  always_comb begin
    out_data = '0;
    if (!w_empty) begin
      out_data    = r_mem[r_head[c_AW-1:0]];
      out_data.en = 1'b1;
    end
  end

  // Pointers carry an extra wrap bit; a plain increment wraps and toggles it.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush && !rst) begin
      r_mem[r_tail[c_AW-1:0]] <= in_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_result_queue.sv
// ============================================================================
// Module : tb_wb_result_queue
// Brief  : Directed self-checking bench for wb_result_queue (DEPTH = 4).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_wb_result_queue;
  import wb_result_queue_pkg::*;

  localparam int c_DEPTH = 4;

  logic       clk;
  logic       rst;
  WBData      in_data;
  logic       in_ready;
  WBData      out_data;
  logic       out_grant;
  logic       flush;
  logic [2:0] count;

  int checks   = 0;
  int failures = 0;

  wb_result_queue #(.DEPTH(c_DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_grant(out_grant),
    .flush    (flush),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic WBData mk(input logic [5:0] idx);
    WBData d;
    d            = '0;
    d.en         = 1'b1;
    d.we         = 1'b1;
    d.robIdx     = idx;
    d.rd         = idx[4:0];
    d.res        = 32'h1000_0000 + 32'(idx);
    d.exccode    = 5'd0;
    d.irq_enable = idx[0];
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_grant = 1'b0; in_data = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_en", 64'(out_data.en), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_zero", 64'(out_data), 64'd0);

    // Three pushes, no grant
    for (int i = 0; i < 3; i++) begin
      in_data = mk(6'(5 + i));
      tick();
    end
    in_data = '0;
    check("p3_count", 64'(count), 64'd3);
    check("p3_head", 64'(out_data.robIdx), 64'd5);
    check("p3_in_ready", 64'(in_ready), 64'd1);
    check("p3_res", 64'(out_data.res), 64'h1000_0005);
    tick();
    check("p3_head_stable", 64'(out_data.robIdx), 64'd5);

    // Fill to four, then offer a fifth
    in_data = mk(6'd8);
    tick();
    check("full_count", 64'(count), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    in_data = mk(6'd9);
    tick();
    check("full_drop_count", 64'(count), 64'd4);
    check("full_drop_head", 64'(out_data.robIdx), 64'd5);

    // Full with grant and an offer in the same cycle
    in_data = mk(6'd10); out_grant = 1'b1;
    check("full_grant_in_ready", 64'(in_ready), 64'd0);
    tick();
    in_data = '0; out_grant = 1'b0;
    check("fg_count", 64'(count), 64'd3);
    check("fg_head", 64'(out_data.robIdx), 64'd6);

    // Pop once to reach count 2 (entries 7, 8)
    out_grant = 1'b1;
    tick();
    check("pop_count", 64'(count), 64'd2);

    // Ten cycles of simultaneous push and pop, pointers wrap
    for (int k = 0; k < 10; k++) begin
      in_data = mk(6'(20 + k));
      check("pp_head", 64'(out_data.robIdx), (k == 0) ? 64'd7 : (k == 1) ? 64'd8 : 64'(20 + k - 2));
      tick();
      check("pp_count", 64'(count), 64'd2);
    end
    in_data = '0; out_grant = 1'b0;
    check("pp_tail_head", 64'(out_data.robIdx), 64'd28);

    // Count 3, then flush together with a push
    in_data = mk(6'd30);
    tick();
    check("pre_flush_count", 64'(count), 64'd3);
    in_data = mk(6'd31); flush = 1'b1;
    tick();
    in_data = '0; flush = 1'b0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_out_en", 64'(out_data.en), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("flush_no_ghost", 64'(out_data.en), 64'd0);

    // Push into empty queue with grant held: one-cycle latency, no bypass
    out_grant = 1'b1; in_data = mk(6'd40);
    check("lat_N_en", 64'(out_data.en), 64'd0);
    tick();
    in_data = '0;
    check("lat_N1_en", 64'(out_data.en), 64'd1);
    check("lat_N1_idx", 64'(out_data.robIdx), 64'd40);
    tick();
    check("lat_N2_count", 64'(count), 64'd0);
    check("lat_N2_en", 64'(out_data.en), 64'd0);
    tick();
    check("empty_grant_count", 64'(count), 64'd0);
    out_grant = 1'b0;

    // Reset mid-operation discards entries
    in_data = mk(6'd50); tick();
    in_data = mk(6'd51); tick();
    check("pre_rst_count", 64'(count), 64'd2);
    in_data = mk(6'd52); rst = 1'b1;
    tick();
    rst = 1'b0; in_data = '0;
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_out_en", 64'(out_data.en), 64'd0);
    in_data = mk(6'd53);
    tick();
    in_data = '0;
    check("post_rst_head", 64'(out_data.robIdx), 64'd53);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
